intersection_arbiter: RTL and testbench

INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

---
 rtl/intersection_arbiter.sv | 137 +++++++++++++
 tb/tb_intersection_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_arbiter.sv
// Four-approach traffic intersection arbiter: GREEN/YELLOW/ALLRED phase FSM with
// latched pending requests and round-robin handover between approaches.
module intersection_arbiter #(
    parameter int MIN_GREEN  = 2,
    parameter int MAX_GREEN  = 6,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    output logic [11:0] lights,
    output logic [1:0]  grant,
    output logic [1:0]  phase,
    output logic [3:0]  pend
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_t;

    localparam logic [3:0] YEL_LAST = 4'(YELLOW_CYC - 1);
    localparam logic [3:0] AR_LAST  = 4'(ALLRED_CYC - 1);
    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] next_q, next_d;
    logic [3:0] pend_q, pend_d;

    logic       contested;
    logic       min_ok;
    logic       max_ok;
    logic       enter_green;
    logic [3:0] req_eff;

    // First pending approach after g, searching g+1, g+2, g+3 modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] g);
        logic [1:0] idx;
        rr_pick = g;
        for (int k = 3; k >= 1; k--) begin
            idx = g + 2'(k);
            if (p[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        contested = |(pend_q & ~(4'b0001 << grant_q));
        min_ok    = ({1'b0, cnt_q} + 5'd1) >= 5'(MIN_GREEN);
        max_ok    = ({1'b0, cnt_q} + 5'd1) >= 5'(MAX_GREEN);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        grant_d     = grant_q;
        next_d      = next_q;
        enter_green = 1'b0;

        case (state_q)
            ST_GREEN: begin
                if (contested && min_ok && (!req[grant_q] || max_ok)) begin
                    state_d = ST_YELLOW;
                    cnt_d   = 4'd0;
                    next_d  = rr_pick(pend_q, grant_q);
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YEL_LAST) begin
                    cnt_d = 4'd0;
                    if (ALLRED_CYC == 0) begin
                        state_d     = ST_GREEN;
                        enter_green = 1'b1;
                    end else begin
                        state_d = ST_ALLRED;
                    end
                end
            end
            ST_ALLRED: begin
                if (cnt_q == AR_LAST) begin
                    state_d     = ST_GREEN;
                    cnt_d       = 4'd0;
                    enter_green = 1'b1;
                end
            end
            default: begin
                state_d = ST_GREEN;
                cnt_d   = 4'd0;
            end
        endcase

        if (enter_green) grant_d = next_q;
    end

    // The green owner's own request is not latched; the incoming owner's bit clears on entry.
    always_comb begin
        req_eff = req;
        if (state_q == ST_GREEN) req_eff[grant_q] = 1'b0;
        pend_d = pend_q | req_eff;
        if (enter_green) pend_d[next_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GREEN;
            cnt_q   <= 4'd0;
            grant_q <= 2'd0;
            next_q  <= 2'd0;
            pend_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            next_q  <= next_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        lights = {L_RED, L_RED, L_RED, L_RED};
        case (state_q)
            ST_GREEN:  lights[3*int'(grant_q) +: 3] = L_GREEN;
            ST_YELLOW: lights[3*int'(grant_q) +: 3] = L_YELLOW;
            default:   lights = {L_RED, L_RED, L_RED, L_RED};
        endcase
    end

    assign grant = grant_q;
    assign phase = state_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_intersection_arbiter.sv
// Scenario bench for intersection_arbiter: default instance plus a
// MIN_GREEN=1 / ALLRED_CYC=0 instance, expected states queued per cycle.
module tb_intersection_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, req2;
    logic [11:0] lights, lights2;
    logic [1:0]  grant, grant2, phase, phase2;
    logic [3:0]  pend, pend2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] g;
        logic [3:0] p;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    intersection_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .lights(lights), .grant(grant), .phase(phase), .pend(pend)
    );

    intersection_arbiter #(.MIN_GREEN(1), .MAX_GREEN(6), .YELLOW_CYC(2), .ALLRED_CYC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2),
        .lights(lights2), .grant(grant2), .phase(phase2), .pend(pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] lt(input logic [1:0] ph, input logic [1:0] g);
        logic [11:0] l;
        l = 12'b100_100_100_100;
        if (ph == 2'b00) l[3*int'(g) +: 3] = 3'b001;
        if (ph == 2'b01) l[3*int'(g) +: 3] = 3'b010;
        return l;
    endfunction

    function automatic bit lights_ok(input logic [11:0] l);
        int nr;
        logic [2:0] s;
        nr = 0;
        for (int i = 0; i < 4; i++) begin
            s = l[3*i +: 3];
            if (s != 3'b100 && s != 3'b010 && s != 3'b001) return 1'b0;
            if (s != 3'b100) nr++;
        end
        return (nr <= 1);
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            n_cmp += 2;
            if (!lights_ok(lights)) begin
                n_bad++;
                $display("FAIL excl_dut1: lights=%b, required one-hot per approach and at most one non-red", lights);
            end
            if (!lights_ok(lights2)) begin
                n_bad++;
                $display("FAIL excl_dut2: lights=%b, required one-hot per approach and at most one non-red", lights2);
            end
        end
    end

    task automatic push(input logic [1:0] ph, input logic [1:0] g, input logic [3:0] p);
        exp_t e;
        e.ph = ph; e.g = g; e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        req = 4'd0; req2 = 4'd0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = 4'd0; req2 = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({phase, grant, pend, lights} !== {2'b00, 2'd0, 4'b0000, 12'b100_100_100_001}) begin
            n_bad++;
            $display("FAIL reset_async: got ph=%b g=%0d pend=%b lights=%b, want 00/0/0000/100100100001",
                     phase, grant, pend, lights);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 20; k++) push(2'b00, 2'd0, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if ({phase, grant, pend, lights} !== {e.ph, e.g, e.p, lt(e.ph, e.g)}) begin
                n_bad++;
                $display("FAIL idle c%0d: got ph=%b g=%0d pend=%b lights=%b, want ph=%b g=%0d pend=%b lights=%b",
                         k, phase, grant, pend, lights, e.ph, e.g, e.p, lt(e.ph, e.g));
            end
            req = 4'd0;
            @(negedge clk);
        end
    endtask

    task automatic test_handover();
        do_reset();
        push(2'b00, 2'd0, 4'b0000); push(2'b00, 2'd0, 4'b0100);
        push(2'b01, 2'd0, 4'b0100); push(2'b01, 2'd0, 4'b0100);
        push(2'b10, 2'd0, 4'b0100); push(2'b00, 2'd2, 4'b0000);
        push(2'b00, 2'd2, 4'b0000);
        for (int k = 0; k < 7; k++) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if ({phase, grant, pend, lights} !== {e.ph, e.g, e.p, lt(e.ph, e.g)}) begin
                n_bad++;
                $display("FAIL handover c%0d: got ph=%b g=%0d pend=%b lights=%b, want ph=%b g=%0d pend=%b lights=%b",
                         k, phase, grant, pend, lights, e.ph, e.g, e.p, lt(e.ph, e.g));
            end
            req = (k == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_max_green();
        do_reset();
        push(2'b00, 2'd0, 4'b0000);
        for (int k = 1; k <= 5; k++) push(2'b00, 2'd0, 4'b0010);
        push(2'b01, 2'd0, 4'b0010); push(2'b01, 2'd0, 4'b0011);
        push(2'b10, 2'd0, 4'b0011); push(2'b00, 2'd1, 4'b0001);
        push(2'b00, 2'd1, 4'b0001); push(2'b01, 2'd1, 4'b0001);
        for (int k = 0; k < 12; k++) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if ({phase, grant, pend, lights} !== {e.ph, e.g, e.p, lt(e.ph, e.g)}) begin
                n_bad++;
                $display("FAIL max_green c%0d: got ph=%b g=%0d pend=%b lights=%b, want ph=%b g=%0d pend=%b lights=%b",
                         k, phase, grant, pend, lights, e.ph, e.g, e.p, lt(e.ph, e.g));
            end
            req = (k == 0) ? 4'b0011 : 4'b0001;
            @(negedge clk);
        end
        req = 4'd0;
    endtask

    task automatic test_round_robin();
        do_reset();
        push(2'b00, 2'd0, 4'b0000); push(2'b00, 2'd0, 4'b0010);
        push(2'b01, 2'd0, 4'b0010); push(2'b01, 2'd0, 4'b1111);
        push(2'b10, 2'd0, 4'b1111);
        push(2'b00, 2'd1, 4'b1101); push(2'b00, 2'd1, 4'b1101);
        push(2'b01, 2'd1, 4'b1101); push(2'b01, 2'd1, 4'b1101); push(2'b10, 2'd1, 4'b1101);
        push(2'b00, 2'd2, 4'b1001); push(2'b00, 2'd2, 4'b1001);
        push(2'b01, 2'd2, 4'b1001); push(2'b01, 2'd2, 4'b1001); push(2'b10, 2'd2, 4'b1001);
        push(2'b00, 2'd3, 4'b0001); push(2'b00, 2'd3, 4'b0001);
        push(2'b01, 2'd3, 4'b0001); push(2'b01, 2'd3, 4'b0001); push(2'b10, 2'd3, 4'b0001);
        push(2'b00, 2'd0, 4'b0000); push(2'b00, 2'd0, 4'b0000);
        for (int k = 0; k < 22; k++) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if ({phase, grant, pend, lights} !== {e.ph, e.g, e.p, lt(e.ph, e.g)}) begin
                n_bad++;
                $display("FAIL round_robin c%0d: got ph=%b g=%0d pend=%b lights=%b, want ph=%b g=%0d pend=%b lights=%b",
                         k, phase, grant, pend, lights, e.ph, e.g, e.p, lt(e.ph, e.g));
            end
            req = (k == 0) ? 4'b0010 : (k == 2) ? 4'b1101 : 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_no_allred();
        do_reset();
        push(2'b00, 2'd0, 4'b0000); push(2'b00, 2'd0, 4'b1000);
        push(2'b01, 2'd0, 4'b1000); push(2'b01, 2'd0, 4'b1000);
        push(2'b00, 2'd3, 4'b0000); push(2'b00, 2'd3, 4'b0010);
        push(2'b01, 2'd3, 4'b0010); push(2'b01, 2'd3, 4'b0011);
        push(2'b00, 2'd1, 4'b0001); push(2'b01, 2'd1, 4'b0001);
        push(2'b01, 2'd1, 4'b0001); push(2'b00, 2'd0, 4'b0000);
        push(2'b00, 2'd0, 4'b0000);
        for (int k = 0; k < 13; k++) begin
            exp_t e = exp_q.pop_front();
            n_cmp += 2;
            if ({phase2, grant2, pend2, lights2} !== {e.ph, e.g, e.p, lt(e.ph, e.g)}) begin
                n_bad++;
                $display("FAIL no_allred c%0d: got ph=%b g=%0d pend=%b lights=%b, want ph=%b g=%0d pend=%b lights=%b",
                         k, phase2, grant2, pend2, lights2, e.ph, e.g, e.p, lt(e.ph, e.g));
            end
            if (phase2 === 2'b10) begin
                n_bad++;
                $display("FAIL no_allred_phase c%0d: got phase=%b, required never 10", k, phase2);
            end
            req2 = (k == 0) ? 4'b1000 : (k == 4) ? 4'b0010 : (k == 6) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_yellow();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (phase !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_yel_pre: got phase=%b, want 01", phase);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({phase, grant, pend, lights} !== {2'b00, 2'd0, 4'b0000, 12'b100_100_100_001}) begin
            n_bad++;
            $display("FAIL rst_yel_async: got ph=%b g=%0d pend=%b lights=%b, want 00/0/0000/100100100001",
                     phase, grant, pend, lights);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) push(2'b00, 2'd0, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if ({phase, grant, pend, lights} !== {e.ph, e.g, e.p, lt(e.ph, e.g)}) begin
                n_bad++;
                $display("FAIL rst_yel_after c%0d: got ph=%b g=%0d pend=%b lights=%b, want ph=%b g=%0d pend=%b lights=%b",
                         k, phase, grant, pend, lights, e.ph, e.g, e.p, lt(e.ph, e.g));
            end
            req = 4'd0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_idle();
        test_handover();
        test_max_green();
        test_round_robin();
        test_no_allred();
        test_reset_in_yellow();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
